// File: rtl/riscv_soft_pkg.sv
// riscv_soft shared types and sizes.
// Imported by writeback, regfile and decode.
package riscv_soft_pkg;

  localparam int XPR_LEN    = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int LD_DEPTH   = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XPR_LEN-1:0]    xpr_t;

endpackage

// File: rtl/riscv_soft_writeback_if.sv
// Writeback bundle: ALU/issue/load inputs,
// hazard queries and the regfile write port.
interface riscv_soft_writeback_if
  import riscv_soft_pkg::*;
();

  logic      alu_valid;
  logic      alu_ready;
  reg_addr_t alu_rd;
  xpr_t      alu_data;

  logic      iss_valid;
  logic      iss_ready;
  reg_addr_t iss_rd;

  logic      ld_valid;
  xpr_t      ld_data;

  reg_addr_t chk_addr_1;
  reg_addr_t chk_addr_2;
  reg_addr_t chk_addr_3;
  logic      busy_1;
  logic      busy_2;
  logic      busy_3;

  logic      wr_en;
  reg_addr_t wr_addr;
  xpr_t      wr_data;
  logic      err_orphan;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  iss_valid, iss_rd,
    output iss_ready,
    input  ld_valid, ld_data,
    input  chk_addr_1, chk_addr_2, chk_addr_3,
    output busy_1, busy_2, busy_3,
    output wr_en, wr_addr, wr_data,
    output err_orphan
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output iss_valid, iss_rd,
    input  iss_ready,
    output ld_valid, ld_data,
    output chk_addr_1, chk_addr_2, chk_addr_3,
    input  busy_1, busy_2, busy_3,
    input  wr_en, wr_addr, wr_data,
    input  err_orphan
  );

endinterface

// File: rtl/riscv_soft_tag_fifo.sv
// In-order destination tags of outstanding loads.
// Extra pointer bit separates full from empty.
module riscv_soft_tag_fifo
  import riscv_soft_pkg::*;
#(
  parameter int DEPTH = LD_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  logic      i_pop,
  input  reg_addr_t i_data,
  output reg_addr_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  reg_addr_t   r_mem [DEPTH];

  wire w_push = i_push && !o_full;
  wire w_pop  = i_pop && !o_empty;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  // Pointer advance on accepted push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Tag storage, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/riscv_soft_writeback.sv
// Merges ALU results and load responses into
// one registered regfile write; tracks hazards.
module riscv_soft_writeback
  import riscv_soft_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  riscv_soft_writeback_if.slave  bus
);

  logic [NUM_REGS-1:0] r_pending;
  logic                r_skid_valid;
  reg_addr_t           r_skid_rd;
  xpr_t                r_skid_data;
  logic                r_wr_en;
  logic                r_wr_ld;
  logic                r_wr_skid;
  reg_addr_t           r_wr_addr;
  xpr_t                r_wr_data;
  logic                r_err;

  logic                w_full;
  logic                w_empty;
  reg_addr_t           w_head;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;

  // alu_ready stays low through the cycle the
  // skid entry is visible on the write port
  wire w_alu_ready = reset && !r_skid_valid &&
                     !r_wr_skid;
  wire w_iss_conf  = (bus.iss_rd != '0) &&
                     r_pending[bus.iss_rd];
  wire w_iss_ready = reset && !w_full && !w_iss_conf;
  wire w_alu_fire  = bus.alu_valid && w_alu_ready;
  wire w_iss_fire  = bus.iss_valid && w_iss_ready;
  wire w_ld_pop    = bus.ld_valid && !w_empty;
  wire w_orphan    = bus.ld_valid && w_empty;

  riscv_soft_tag_fifo #(
    .DEPTH (LD_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_iss_fire),
    .i_pop   (w_ld_pop),
    .i_data  (bus.iss_rd),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  function automatic logic f_busy(reg_addr_t a);
    logic hit;
    hit = r_pending[a] ||
          (r_skid_valid && r_skid_rd == a) ||
          (r_wr_en && r_wr_addr == a);
    return (a != '0) && hit;
  endfunction

  assign bus.alu_ready  = w_alu_ready;
  assign bus.iss_ready  = w_iss_ready;
  assign bus.busy_1     = f_busy(bus.chk_addr_1);
  assign bus.busy_2     = f_busy(bus.chk_addr_2);
  assign bus.busy_3     = f_busy(bus.chk_addr_3);
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.err_orphan = r_err;

  // Per-register set on issue, clear on commit
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_iss_fire && bus.iss_rd != '0)
      w_set[bus.iss_rd] = 1'b1;
    if (r_wr_en && r_wr_ld)
      w_clr[r_wr_addr] = 1'b1;
  end

  // Pending scoreboard update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_clr) | w_set;
  end

  // Skid captures an ALU result that loses to a load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_skid_valid <= 1'b0;
      r_skid_rd    <= '0;
      r_skid_data  <= '0;
    end else if (bus.ld_valid && w_alu_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_rd    <= bus.alu_rd;
      r_skid_data  <= bus.alu_data;
    end else if (!bus.ld_valid) begin
      r_skid_valid <= 1'b0;
    end
  end

  // Write port: load, then skid, then fresh ALU
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en   <= 1'b0;
      r_wr_ld   <= 1'b0;
      r_wr_skid <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err     <= w_orphan;
      r_wr_en   <= 1'b0;
      r_wr_ld   <= 1'b0;
      r_wr_skid <= 1'b0;
      if (w_ld_pop) begin
        r_wr_en   <= (w_head != '0);
        r_wr_ld   <= 1'b1;
        r_wr_addr <= w_head;
        r_wr_data <= bus.ld_data;
      end else if (!bus.ld_valid && r_skid_valid) begin
        r_wr_en   <= (r_skid_rd != '0);
        r_wr_skid <= 1'b1;
        r_wr_addr <= r_skid_rd;
        r_wr_data <= r_skid_data;
      end else if (!bus.ld_valid && w_alu_fire) begin
        r_wr_en   <= (bus.alu_rd != '0);
        r_wr_addr <= bus.alu_rd;
        r_wr_data <= bus.alu_data;
      end
    end
  end

endmodule
